// File: rtl/fpu_addsub_arbiter.sv
// Round-robin arbiter sharing one pipelined FP32 add/sub unit among NUM_REQ lanes; a tag pipeline
// steers each result back to its issuer. Define FPU_ARB_STAT_EN for a saturating overflow counter.
module fpu_addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int DATA_W  = 32,
    parameter int FPU_LAT = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_hold,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_op_a,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_op_b,
    input  logic [NUM_REQ-1:0]          i_req_sub,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic                        o_fpu_valid,
    output logic [DATA_W-1:0]           o_fpu_a,
    output logic [DATA_W-1:0]           o_fpu_b,
    output logic                        o_fpu_sub,
    input  logic [DATA_W-1:0]           i_fpu_result,
    input  logic                        i_fpu_ov_flow,
    output logic [NUM_REQ-1:0]          o_rsp_valid,
    output logic [DATA_W-1:0]           o_rsp_data,
    output logic                        o_rsp_ov_flow,
    output logic                        o_busy
`ifdef FPU_ARB_STAT_EN
    ,
    input  logic                        i_stat_clr,
    output logic [15:0]                 o_ov_count
`endif
);

    localparam int IW = (ID_W < 1) ? 1 : ID_W;

    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        gnt_id;
    logic                 gnt_vld;
    logic [NUM_REQ-1:0]   gnt;
    logic [DATA_W-1:0]    sel_a, sel_b;
    logic                 sel_sub;

    logic                 fpu_valid_q, fpu_valid_d;
    logic [DATA_W-1:0]    fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
    logic                 fpu_sub_q, fpu_sub_d;
    logic [IW-1:0]        fpu_id_q, fpu_id_d;

    logic [FPU_LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [IW-1:0]        tag_id_q [FPU_LAT];
    logic [IW-1:0]        tag_id_d [FPU_LAT];

    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 rsp_ov_q, rsp_ov_d;

    // Stage 0: pick the requester closest to the pointer (circular distance), then mux its operands
    always_comb begin
        int best;
        best    = NUM_REQ;
        gnt_id  = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        gnt     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_req_valid[k] && (((k - int'(ptr_q) + NUM_REQ) % NUM_REQ) < best)) begin
                best   = (k - int'(ptr_q) + NUM_REQ) % NUM_REQ;
                gnt_id = IW'(k);
            end
        end
        gnt_vld = (best < NUM_REQ) && i_rst_n && !i_hold;
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt[k] = gnt_vld && (gnt_id == IW'(k));
            if (gnt_id == IW'(k)) begin
                sel_a   = i_req_op_a[k*DATA_W +: DATA_W];
                sel_b   = i_req_op_b[k*DATA_W +: DATA_W];
                sel_sub = i_req_sub[k];
            end
        end
        ptr_d = gnt_vld ? IW'((int'(gnt_id) + 1) % NUM_REQ) : ptr_q;
    end

    // Stage 1: issue register feeding the unit; operands hold when nothing is issued
    always_comb begin
        fpu_valid_d = gnt_vld;
        fpu_a_d     = gnt_vld ? sel_a   : fpu_a_q;
        fpu_b_d     = gnt_vld ? sel_b   : fpu_b_q;
        fpu_sub_d   = gnt_vld ? sel_sub : fpu_sub_q;
        fpu_id_d    = gnt_vld ? gnt_id  : fpu_id_q;
    end

    // Tag stages: free-running shift that mirrors the unit's latency
    always_comb begin
        tag_vld_d[0] = fpu_valid_q;
        tag_id_d[0]  = fpu_id_q;
        for (int s = 1; s < FPU_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
    end

    // Response stage: result is captured only when the last tag stage owns it
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_ov_d    = rsp_ov_q;
        if (tag_vld_q[FPU_LAT-1]) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                rsp_valid_d[k] = (tag_id_q[FPU_LAT-1] == IW'(k));
            end
            rsp_data_d = i_fpu_result;
            rsp_ov_d   = i_fpu_ov_flow;
        end
    end

`ifdef FPU_ARB_STAT_EN
    logic [15:0] ov_count_q, ov_count_d;

    always_comb begin
        ov_count_d = ov_count_q;
        if (i_stat_clr) begin
            ov_count_d = '0;
        end else if (tag_vld_q[FPU_LAT-1] && i_fpu_ov_flow && (ov_count_q != 16'hFFFF)) begin
            ov_count_d = ov_count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ov_count_q <= '0;
        else          ov_count_q <= ov_count_d;
    end

    assign o_ov_count = ov_count_q;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q       <= '0;
            fpu_valid_q <= 1'b0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            fpu_sub_q   <= 1'b0;
            fpu_id_q    <= '0;
            tag_vld_q   <= '0;
            for (int s = 0; s < FPU_LAT; s++) tag_id_q[s] <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_ov_q    <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            fpu_valid_q <= fpu_valid_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_sub_q   <= fpu_sub_d;
            fpu_id_q    <= fpu_id_d;
            tag_vld_q   <= tag_vld_d;
            for (int s = 0; s < FPU_LAT; s++) tag_id_q[s] <= tag_id_d[s];
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ov_q    <= rsp_ov_d;
        end
    end

    assign o_req_ready   = gnt;
    assign o_fpu_valid   = fpu_valid_q;
    assign o_fpu_a       = fpu_a_q;
    assign o_fpu_b       = fpu_b_q;
    assign o_fpu_sub     = fpu_sub_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rsp_ov_flow = rsp_ov_q;
    assign o_busy        = fpu_valid_q | (|tag_vld_q);

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Bench for fpu_addsub_arbiter: directed scenarios plus random traffic against a cycle-indexed
// scoreboard; a behavioural FP32 add/sub stub with FPU_LAT delay stands in for the shared unit.
module tb_fpu_addsub_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int LAT  = 3;
    localparam int MAXC = 2048;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b1;
    logic              i_hold = 1'b0;
    logic [N-1:0]      i_req_valid = '0;
    logic [N*DW-1:0]   i_req_op_a = '0;
    logic [N*DW-1:0]   i_req_op_b = '0;
    logic [N-1:0]      i_req_sub = '0;
    logic [N-1:0]      o_req_ready;
    logic              o_fpu_valid;
    logic [DW-1:0]     o_fpu_a, o_fpu_b;
    logic              o_fpu_sub;
    logic [DW-1:0]     i_fpu_result;
    logic              i_fpu_ov_flow;
    logic [N-1:0]      o_rsp_valid;
    logic [DW-1:0]     o_rsp_data;
    logic              o_rsp_ov_flow;
    logic              o_busy;
`ifdef FPU_ARB_STAT_EN
    logic              i_stat_clr = 1'b0;
    logic [15:0]       o_ov_count;
    logic [15:0]       m_ovc;
`endif

    fpu_addsub_arbiter #(.NUM_REQ(N), .DATA_W(DW), .FPU_LAT(LAT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hold(i_hold),
        .i_req_valid(i_req_valid), .i_req_op_a(i_req_op_a), .i_req_op_b(i_req_op_b),
        .i_req_sub(i_req_sub), .o_req_ready(o_req_ready),
        .o_fpu_valid(o_fpu_valid), .o_fpu_a(o_fpu_a), .o_fpu_b(o_fpu_b), .o_fpu_sub(o_fpu_sub),
        .i_fpu_result(i_fpu_result), .i_fpu_ov_flow(i_fpu_ov_flow),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_ov_flow(o_rsp_ov_flow),
        .o_busy(o_busy)
`ifdef FPU_ARB_STAT_EN
        , .i_stat_clr(i_stat_clr), .o_ov_count(o_ov_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    // FP32 <-> real helpers (normal numbers and zero only)
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_addsub(input logic [31:0] a, input logic [31:0] b, input logic s);
        return r2f(s ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b)));
    endfunction

    // Unit stub: fixed FPU_LAT delay; overflow reported when operand A's LSB is set, junk when idle
    logic [31:0] sd [LAT];
    logic        so [LAT];
    always @(posedge i_clk) begin
        sd[0] <= o_fpu_valid ? fp_addsub(o_fpu_a, o_fpu_b, o_fpu_sub) : $urandom;
        so[0] <= o_fpu_valid ? o_fpu_a[0] : 1'($urandom);
        for (int s = 1; s < LAT; s++) begin
            sd[s] <= sd[s-1];
            so[s] <= so[s-1];
        end
    end
    assign i_fpu_result  = sd[LAT-1];
    assign i_fpu_ov_flow = so[LAT-1];

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          m_ptr = 0;
    int          exp_lane [MAXC];
    logic [31:0] exp_data [MAXC];
    logic        exp_ov   [MAXC];
    logic        exp_fv   [MAXC];
    logic        hs_at    [MAXC];
    logic [31:0] m_fa, m_fb, m_rd;
    logic        m_fs, m_ro;
    logic [31:0] op_a [N];
    logic [31:0] op_b [N];
    logic        op_s [N];
    int          dq[$];
    int          rq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < MAXC; k++) begin
            hs_at[k] = 1'b0;
            if (k > cyc) begin
                exp_lane[k] = -1;
                exp_fv[k]   = 1'b0;
            end
        end
        m_ptr = 0; m_fa = '0; m_fb = '0; m_fs = 1'b0; m_rd = '0; m_ro = 1'b0;
`ifdef FPU_ARB_STAT_EN
        m_ovc = '0;
`endif
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            op_a[k] = r2f(real'($urandom_range(1, 1000))) | 32'($urandom_range(0, 1));
            op_b[k] = r2f(real'($urandom_range(1, 1000))) | 32'($urandom_range(0, 1));
            op_s[k] = 1'($urandom_range(0, 1));
        end
    endtask

    // One clock: check registered outputs, drive inputs, then check the grant against the model
    task automatic tick(input logic [N-1:0] v, input logic h = 1'b0, input logic rn = 1'b1);
        logic [N-1:0] eg;
        logic         eb;
        int           g;
        @(negedge i_clk);
        cyc++;
        if (exp_lane[cyc] >= 0) begin
            m_rd = exp_data[cyc];
            m_ro = exp_ov[cyc];
`ifdef FPU_ARB_STAT_EN
            if (m_ro && m_ovc != 16'hFFFF) m_ovc++;
`endif
        end
        chk("rsp_valid", 32'(o_rsp_valid), (exp_lane[cyc] >= 0) ? (32'd1 << exp_lane[cyc]) : 32'd0);
        chk("rsp_data", o_rsp_data, m_rd);
        chk("rsp_ov", 32'(o_rsp_ov_flow), 32'(m_ro));
        chk("fpu_valid", 32'(o_fpu_valid), 32'(exp_fv[cyc]));
        chk("fpu_a", o_fpu_a, m_fa);
        chk("fpu_b", o_fpu_b, m_fb);
        chk("fpu_sub", 32'(o_fpu_sub), 32'(m_fs));
        eb = 1'b0;
        for (int k = cyc - 1 - LAT; k <= cyc - 1; k++) if (k >= 0 && hs_at[k]) eb = 1'b1;
        chk("busy", 32'(o_busy), 32'(eb));
`ifdef FPU_ARB_STAT_EN
        chk("ov_count", 32'(o_ov_count), 32'(m_ovc));
`endif
        for (int k = 0; k < N; k++) if (o_rsp_valid[k]) rq.push_back(k);

        i_rst_n = rn; i_hold = h; i_req_valid = v;
        for (int k = 0; k < N; k++) begin
            i_req_op_a[k*DW +: DW] = op_a[k];
            i_req_op_b[k*DW +: DW] = op_b[k];
            i_req_sub[k]           = op_s[k];
        end
        #1;
        if (!rn) begin
            model_reset();
            chk("rst_fpu_valid", 32'(o_fpu_valid), 32'd0);
            chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);
        end
        eg = '0; g = -1;
        if (rn && !h) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        chk("req_ready", 32'(o_req_ready), 32'(eg));
        for (int k = 0; k < N; k++) if (o_req_ready[k]) dq.push_back(k);
        if (g >= 0) begin
            hs_at[cyc]              = 1'b1;
            exp_fv[cyc+1]           = 1'b1;
            m_fa = op_a[g]; m_fb = op_b[g]; m_fs = op_s[g];
            exp_lane[cyc+LAT+2]     = g;
            exp_data[cyc+LAT+2]     = fp_addsub(op_a[g], op_b[g], op_s[g]);
            exp_ov[cyc+LAT+2]       = op_a[g][0];
            m_ptr                   = (g + 1) % N;
        end
    endtask

    initial begin
        for (int k = 0; k < MAXC; k++) begin
            exp_lane[k] = -1; exp_fv[k] = 1'b0; hs_at[k] = 1'b0;
            exp_data[k] = '0; exp_ov[k] = 1'b0;
        end
        model_reset();
        rand_ops();
        #1 i_rst_n = 1'b0;
        tick('1, 1'b0, 1'b0);
        tick('1, 1'b0, 1'b0);

        // Round-robin from pointer 0
        dq.delete(); rq.delete();
        for (int i = 0; i < 8; i++) tick('1);
        for (int i = 0; i < LAT + 3; i++) tick('0);
        for (int i = 0; i < 8; i++) begin
            chk("rr_grant", 32'(dq[i]), 32'(i % 4));
            chk("rr_rsp", 32'(rq[i]), 32'(i % 4));
        end

        // Single op on lane 2: 1.0 + 2.0
        op_a[2] = 32'h3F800000; op_b[2] = 32'h40000000; op_s[2] = 1'b0;
        tick(4'b0100);
        chk("single_ready", 32'(o_req_ready), 32'h4);
        tick('0);
        chk("single_issue", 32'(o_fpu_valid), 32'd1);
        for (int i = 0; i < 4; i++) tick('0);
        chk("single_rsp_valid", 32'(o_rsp_valid), 32'h4);
        chk("single_rsp_data", o_rsp_data, 32'h40400000);

        // Wrap and skip: pointer now 3, lanes 1 and 3 requesting
        dq.delete();
        rand_ops();
        for (int i = 0; i < 3; i++) tick(4'b1010);
        chk("wrap_g0", 32'(dq[0]), 32'd3);
        chk("wrap_g1", 32'(dq[1]), 32'd1);
        chk("wrap_g2", 32'(dq[2]), 32'd3);
        for (int i = 0; i < LAT + 3; i++) tick('0);

        // Hold with two ops in flight
        rand_ops();
        tick('1); tick('1);
        for (int i = 0; i < 4; i++) begin
            tick('1, 1'b1);
            chk("hold_ready", 32'(o_req_ready), 32'd0);
        end
        tick('0); tick('0);
        chk("hold_idle", 32'(o_busy), 32'd0);

        // Overflow reported for lane 1
        op_a[1] = 32'h3F800001; op_b[1] = 32'h40000000; op_s[1] = 1'b1;
        tick(4'b0010);
        for (int i = 0; i < LAT + 2; i++) tick('0);
        chk("ov_rsp_valid", 32'(o_rsp_valid), 32'h2);
        chk("ov_flag", 32'(o_rsp_ov_flow), 32'd1);

        // Reset with three ops in flight, then a fresh grant from pointer 0
        rand_ops();
        tick('1); tick('1); tick('1);
        tick('1, 1'b0, 1'b0);
        tick('1, 1'b0, 1'b0);
        tick(4'b1001);
        chk("post_rst_grant", 32'(o_req_ready), 32'h1);
        for (int i = 0; i < LAT + 3; i++) tick('0);

        // Random traffic with occasional hold
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            tick(N'($urandom), 1'($urandom_range(0, 7) == 0));
        end
        for (int i = 0; i < LAT + 4; i++) tick('0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
